dmem_port_arbiter: RTL and testbench

Shares the single data-memory port between two requesters: the core load/store path (port C, fed by the store unit's aligned outputs and the load path) and a DMA/debug master (port D). Round-robin arbitration, one outstanding transaction, and a memory-side ready/valid handshake with stall and timeout handling. Sits between the core LSU/DMA and the data memory.

---
 rtl/dmem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between core (C) and DMA (D).
// Round-robin grant, one outstanding transaction, stall and timeout handling.
module dmem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        c_req_in,
    input  logic        c_we_in,
    input  logic [31:0] c_addr_in,
    input  logic [31:0] c_wdata_in,
    input  logic [3:0]  c_mask_in,
    output logic        c_ack_out,
    output logic        c_err_out,
    output logic [31:0] c_rdata_out,
    input  logic        d_req_in,
    input  logic        d_we_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    input  logic [3:0]  d_mask_in,
    output logic        d_ack_out,
    output logic        d_err_out,
    output logic [31:0] d_rdata_out,
    output logic        dm_req_out,
    output logic        dm_we_out,
    output logic [31:0] dmaddr_out,
    output logic [31:0] dmdata_out,
    output logic [3:0]  dmwr_mask_out,
    input  logic        dm_ready_in,
    input  logic [31:0] dm_rdata_in,
    input  logic        dm_rvalid_in,
    output logic        busy_out,
    output logic        grant_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

    state_t      state;
    logic        last_grant;
    logic [15:0] to_cnt;

    logic        c_elig;
    logic        d_elig;
    logic        any_elig;
    logic        win_d;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_mask;
    logic        to_hit;
    logic [15:0] to_next;

    // Arbitration, request field selection and timeout detection.
    always_comb begin
        c_elig    = c_req_in & ~c_ack_out;
        d_elig    = d_req_in & ~d_ack_out;
        any_elig  = c_elig | d_elig;
        win_d     = (c_elig & d_elig) ? ~last_grant : d_elig;
        sel_we    = win_d ? d_we_in    : c_we_in;
        sel_addr  = win_d ? d_addr_in  : c_addr_in;
        sel_wdata = win_d ? d_wdata_in : c_wdata_in;
        sel_mask  = win_d ? d_mask_in  : c_mask_in;
        to_hit    = TO_EN && (({1'b0, to_cnt} + 17'd1) == TO_LIM);
        to_next   = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            to_cnt        <= 16'd0;
            c_ack_out     <= 1'b0;
            c_err_out     <= 1'b0;
            c_rdata_out   <= 32'd0;
            d_ack_out     <= 1'b0;
            d_err_out     <= 1'b0;
            d_rdata_out   <= 32'd0;
            dm_req_out    <= 1'b0;
            dm_we_out     <= 1'b0;
            dmaddr_out    <= 32'd0;
            dmdata_out    <= 32'd0;
            dmwr_mask_out <= 4'd0;
            busy_out      <= 1'b0;
            grant_out     <= 1'b0;
        end else begin
            c_ack_out <= 1'b0;
            c_err_out <= 1'b0;
            d_ack_out <= 1'b0;
            d_err_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_elig) begin
                        grant_out     <= win_d;
                        last_grant    <= win_d;
                        dmaddr_out    <= sel_addr & ~32'h3;
                        dmdata_out    <= sel_wdata;
                        dm_we_out     <= sel_we;
                        dmwr_mask_out <= sel_we ? sel_mask : 4'b0000;
                        if (sel_we && (sel_mask == 4'b0000)) begin
                            if (win_d) d_ack_out <= 1'b1;
                            else       c_ack_out <= 1'b1;
                        end else begin
                            dm_req_out <= 1'b1;
                            busy_out   <= 1'b1;
                            to_cnt     <= 16'd0;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (dm_ready_in && dm_we_out) begin
                        dm_req_out <= 1'b0;
                        busy_out   <= 1'b0;
                        state      <= IDLE;
                        if (grant_out) d_ack_out <= 1'b1;
                        else           c_ack_out <= 1'b1;
                    end else if (to_hit) begin
                        dm_req_out <= 1'b0;
                        busy_out   <= 1'b0;
                        state      <= IDLE;
                        if (grant_out) begin
                            d_ack_out   <= 1'b1;
                            d_err_out   <= 1'b1;
                            d_rdata_out <= 32'd0;
                        end else begin
                            c_ack_out   <= 1'b1;
                            c_err_out   <= 1'b1;
                            c_rdata_out <= 32'd0;
                        end
                    end else begin
                        to_cnt <= to_next;
                        if (dm_ready_in) begin
                            dm_req_out <= 1'b0;
                            state      <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (dm_rvalid_in) begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                        if (grant_out) begin
                            d_ack_out   <= 1'b1;
                            d_rdata_out <= dm_rdata_in;
                        end else begin
                            c_ack_out   <= 1'b1;
                            c_rdata_out <= dm_rdata_in;
                        end
                    end else if (to_hit) begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                        if (grant_out) begin
                            d_ack_out   <= 1'b1;
                            d_err_out   <= 1'b1;
                            d_rdata_out <= 32'd0;
                        end else begin
                            c_ack_out   <= 1'b1;
                            c_err_out   <= 1'b1;
                            c_rdata_out <= 32'd0;
                        end
                    end else begin
                        to_cnt <= to_next;
                    end
                end
                default: begin
                    dm_req_out <= 1'b0;
                    busy_out   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench for dmem_port_arbiter.
// Expected acks are queued at request time and matched when acks appear.
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [3:0]  c_mask, d_mask;
    logic        c_ack, c_err, d_ack, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        dm_req, dm_we, dm_ready, dm_rvalid;
    logic [31:0] dm_addr, dm_data, dm_rdata;
    logic [3:0]  dm_mask;
    logic        busy, grant;

    logic        t_c_req, t_c_we;
    logic [31:0] t_c_addr, t_c_wdata;
    logic [3:0]  t_c_mask;
    logic        t_c_ack, t_c_err;
    logic [31:0] t_c_rdata;
    logic        t_d_req = 1'b0, t_d_we = 1'b0;
    logic [31:0] t_d_addr = 32'd0, t_d_wdata = 32'd0;
    logic [3:0]  t_d_mask = 4'd0;
    logic        t_d_ack, t_d_err;
    logic [31:0] t_d_rdata;
    logic        t_dm_req, t_dm_we, t_dm_ready, t_dm_rvalid;
    logic [31:0] t_dm_addr, t_dm_data, t_dm_rdata;
    logic [3:0]  t_dm_mask;
    logic        t_busy, t_grant;

    dmem_port_arbiter u_dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .c_req_in(c_req), .c_we_in(c_we), .c_addr_in(c_addr),
        .c_wdata_in(c_wdata), .c_mask_in(c_mask),
        .c_ack_out(c_ack), .c_err_out(c_err), .c_rdata_out(c_rdata),
        .d_req_in(d_req), .d_we_in(d_we), .d_addr_in(d_addr),
        .d_wdata_in(d_wdata), .d_mask_in(d_mask),
        .d_ack_out(d_ack), .d_err_out(d_err), .d_rdata_out(d_rdata),
        .dm_req_out(dm_req), .dm_we_out(dm_we), .dmaddr_out(dm_addr),
        .dmdata_out(dm_data), .dmwr_mask_out(dm_mask),
        .dm_ready_in(dm_ready), .dm_rdata_in(dm_rdata),
        .dm_rvalid_in(dm_rvalid),
        .busy_out(busy), .grant_out(grant)
    );

    dmem_port_arbiter #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .clk_in(clk), .rst_n_in(rst_n),
        .c_req_in(t_c_req), .c_we_in(t_c_we), .c_addr_in(t_c_addr),
        .c_wdata_in(t_c_wdata), .c_mask_in(t_c_mask),
        .c_ack_out(t_c_ack), .c_err_out(t_c_err), .c_rdata_out(t_c_rdata),
        .d_req_in(t_d_req), .d_we_in(t_d_we), .d_addr_in(t_d_addr),
        .d_wdata_in(t_d_wdata), .d_mask_in(t_d_mask),
        .d_ack_out(t_d_ack), .d_err_out(t_d_err), .d_rdata_out(t_d_rdata),
        .dm_req_out(t_dm_req), .dm_we_out(t_dm_we), .dmaddr_out(t_dm_addr),
        .dmdata_out(t_dm_data), .dmwr_mask_out(t_dm_mask),
        .dm_ready_in(t_dm_ready), .dm_rdata_in(t_dm_rdata),
        .dm_rvalid_in(t_dm_rvalid),
        .busy_out(t_busy), .grant_out(t_grant)
    );

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] c_rd = 32'd0;
    logic [31:0] d_rd = 32'd0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic port, input logic err,
                        input logic [31:0] rd);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input logic port);
        int n = 0;
        while (!(port ? d_ack : c_ack) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ack_wait", 32'(n < 40), 32'd1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        c_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c_rd  = 32'd0;
        d_rd  = 32'd0;
    endtask

    always @(negedge clk) begin
        if (rst_n && (c_ack || d_ack)) begin
            if (sb.size() == 0) begin
                check("unexp_ack", {30'd0, d_ack, c_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_port", {30'd0, d_ack, c_ack},
                      e.port ? 32'd2 : 32'd1);
                check("ack_err", 32'(e.port ? d_err : c_err), 32'(e.err));
                check("ack_rdata", e.port ? d_rdata : c_rdata, e.rdata);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        {c_req, c_we, d_req, d_we} = '0;
        {c_addr, c_wdata, d_addr, d_wdata} = '0;
        {c_mask, d_mask} = '0;
        {dm_ready, dm_rvalid} = '0;
        dm_rdata = '0;
        {t_c_req, t_c_we, t_dm_ready, t_dm_rvalid} = '0;
        {t_c_addr, t_c_wdata, t_dm_rdata} = '0;
        t_c_mask = '0;
        repeat (2) @(negedge clk);
        check("rst_acks", {28'd0, c_ack, d_ack, c_err, d_err}, 32'd0);
        check("rst_dm", {24'd0, dm_req, dm_we, dm_mask, busy, grant}, 32'd0);
        check("rst_addr", dm_addr | dm_data, 32'd0);
        check("rst_rdata", c_rdata | d_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single core write
        dm_ready = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h1003;
        c_mask = 4'b1000; c_wdata = 32'hAB000000;
        push(1'b0, 1'b0, c_rd);
        @(negedge clk);
        check("t1_req", 32'(dm_req), 32'd1);
        check("t1_addr", dm_addr, 32'h1000);
        check("t1_mask", 32'(dm_mask), 32'h8);
        check("t1_data", dm_data, 32'hAB000000);
        check("t1_we", 32'(dm_we), 32'd1);
        check("t1_grant", 32'(grant), 32'd0);
        @(negedge clk);
        check("t1_cack", 32'(c_ack), 32'd1);
        check("t1_req_drop", 32'(dm_req), 32'd0);
        check("t1_dack", 32'(d_ack), 32'd0);
        c_req = 1'b0;
        @(negedge clk);
        check("t1_pulse", 32'(c_ack), 32'd0);

        // tie out of reset: C first, then D
        reset_dut();
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h100; c_mask = 4'hF;
        c_wdata = 32'h11223344;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h206; d_mask = 4'h3;
        d_wdata = 32'h55667788;
        push(1'b0, 1'b0, c_rd);
        push(1'b1, 1'b0, d_rd);
        @(negedge clk);
        check("t2_grant_c", 32'(grant), 32'd0);
        check("t2_addr_c", dm_addr, 32'h100);
        @(negedge clk);
        check("t2_cack", 32'(c_ack), 32'd1);
        @(negedge clk);
        check("t2_grant_d", 32'(grant), 32'd1);
        check("t2_req_d", 32'(dm_req), 32'd1);
        check("t2_addr_d", dm_addr, 32'h204);
        check("t2_mask_d", 32'(dm_mask), 32'h3);
        c_req = 1'b0;
        @(negedge clk);
        check("t2_dack", 32'(d_ack), 32'd1);
        d_req = 1'b0;
        @(negedge clk);

        // DMA read with stalls; rvalid on the accept cycle is ignored
        dm_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_mask = 4'hF;
        push(1'b1, 1'b0, 32'hDEADBEEF);
        d_rd = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_req", 32'(dm_req), 32'd1);
            check("t3_addr", dm_addr, 32'h20);
            check("t3_mask", 32'(dm_mask), 32'd0);
            check("t3_we", 32'(dm_we), 32'd0);
        end
        dm_ready = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h11111111;
        @(negedge clk);
        check("t3_accept", 32'(dm_req), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_early", 32'(d_ack), 32'd0);
        dm_ready = 1'b0; dm_rvalid = 1'b0;
        @(negedge clk);
        dm_rvalid = 1'b1; dm_rdata = 32'hDEADBEEF;
        wait_ack(1'b1);
        check("t3_cack", 32'(c_ack), 32'd0);
        dm_rvalid = 1'b0;
        d_req = 1'b0;
        @(negedge clk);

        // timeout on the TIMEOUT_CYCLES=4 instance
        t_dm_ready = 1'b1;
        t_c_req = 1'b1; t_c_we = 1'b0; t_c_addr = 32'h44;
        @(negedge clk);
        @(negedge clk);
        t_dm_rvalid = 1'b1; t_dm_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        check("t4_ok_ack", 32'(t_c_ack), 32'd1);
        check("t4_ok_err", 32'(t_c_err), 32'd0);
        check("t4_ok_rd", t_c_rdata, 32'h5A5A5A5A);
        t_c_req = 1'b0; t_dm_rvalid = 1'b0; t_dm_ready = 1'b0;
        @(negedge clk);
        t_c_req = 1'b1; t_c_addr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_hold", 32'(t_dm_req), 32'd1);
            check("t4_noack", 32'(t_c_ack), 32'd0);
        end
        @(negedge clk);
        check("t4_ack", 32'(t_c_ack), 32'd1);
        check("t4_err", 32'(t_c_err), 32'd1);
        check("t4_rdata", t_c_rdata, 32'd0);
        check("t4_req", 32'(t_dm_req), 32'd0);
        check("t4_busy", 32'(t_busy), 32'd0);
        t_c_req = 1'b0;
        @(negedge clk);
        check("t4_errpulse", 32'(t_c_err), 32'd0);

        // zero-mask write: no memory access
        dm_ready = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h300; c_mask = 4'h0;
        push(1'b0, 1'b0, c_rd);
        @(negedge clk);
        check("t5_ack", 32'(c_ack), 32'd1);
        check("t5_noreq", 32'(dm_req), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        c_req = 1'b0;
        @(negedge clk);
        check("t5_noreq2", 32'(dm_req), 32'd0);

        // reset during WAIT_R abandons the read
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h80; c_mask = 4'h0;
        @(negedge clk);
        check("t6_req", 32'(dm_req), 32'd1);
        @(negedge clk);
        check("t6_wait", {30'd0, busy, dm_req}, 32'd2);
        dm_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_d", d_rdata, 32'd0);
        check("t6_rst_busy", {30'd0, busy, dm_req}, 32'd0);
        check("t6_rst_addr", dm_addr, 32'd0);
        c_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        c_rd = 32'd0; d_rd = 32'd0;
        repeat (3) @(negedge clk);
        dm_ready = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h400; c_mask = 4'h1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_mask = 4'h2;
        push(1'b0, 1'b0, c_rd);
        push(1'b1, 1'b0, d_rd);
        @(negedge clk);
        check("t6_grant_c", 32'(grant), 32'd0);
        wait_ack(1'b0);
        c_req = 1'b0;
        wait_ack(1'b1);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
